// File: rtl/life_gen_sequencer_pkg.sv
// Shared types for the Life grid sequencer: datapath operation codes and controller states.
package life_pkg;

    localparam int GRID_W = 64;

    typedef enum logic [1:0] {
        OP_NOP       = 2'b00,
        OP_LOAD_SEED = 2'b01,
        OP_LOAD_RAND = 2'b10,
        OP_EVOLVE    = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        PACE
    } state_t;

endpackage

// File: rtl/life_gen_sequencer_tick_divider.sv
// Generation pacing counter: counts 0..TICK_DIV-1 while enabled, pulses term on the last count.
module tick_divider #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic term
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] tick_reg;

    assign term = en && (tick_reg == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_reg <= '0;
        end else if (clr) begin
            tick_reg <= '0;
        end else if (en) begin
            tick_reg <= term ? '0 : tick_reg + 1'b1;
        end
    end

endmodule

// File: rtl/life_gen_sequencer.sv
// Sequences one-at-a-time req/ack operations on the Life grid datapath from user controls,
// paces run-mode generations, counts generations and detects a stable board.
module life_gen_sequencer #(
    parameter int TICK_DIV = 50_000_000,
    parameter int GEN_W    = 16,
    parameter int GRID_W   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              rundom,
    input  logic              step,
    input  logic              run,
    input  logic [GRID_W-1:0] grid,
    input  logic              grid_ack,
    output logic              grid_req,
    output logic [1:0]        grid_op,
    output logic [GEN_W-1:0]  gen_count,
    output logic              stable,
    output logic              busy
);

    import life_pkg::*;

    state_t            state_reg, state_next;
    op_t               op_reg, op_next;
    logic              from_run_reg, from_run_next;
    logic [GEN_W-1:0]  gen_reg;
    logic              stable_reg;
    logic [GRID_W-1:0] prev_grid_reg;
    logic              pace_entry;
    logic              ack_done;
    logic              tick_clr;
    logic              tick_en;
    logic              tick_term;

    assign ack_done = (state_reg == WAIT) && grid_ack;

    // The ack cycle itself is tick 0, so the next run-mode req rises TICK_DIV cycles after ack.
    assign tick_clr = !((state_reg == PACE) || pace_entry);
    assign tick_en  = !tick_clr;

    tick_divider #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .clr  (tick_clr),
        .en   (tick_en),
        .term (tick_term)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            op_reg       <= OP_NOP;
            from_run_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            op_reg       <= op_next;
            from_run_reg <= from_run_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        op_next       = op_reg;
        from_run_next = from_run_reg;
        pace_entry    = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (load) begin
                    op_next       = OP_LOAD_SEED;
                    from_run_next = 1'b0;
                    state_next    = ISSUE;
                end else if (rundom) begin
                    op_next       = OP_LOAD_RAND;
                    from_run_next = 1'b0;
                    state_next    = ISSUE;
                end else if (step) begin
                    op_next       = OP_EVOLVE;
                    from_run_next = 1'b0;
                    state_next    = ISSUE;
                end else if (run && !stable_reg) begin
                    op_next       = OP_EVOLVE;
                    from_run_next = 1'b1;
                    state_next    = ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (grid_ack) begin
                    op_next = OP_NOP;
                    if (op_reg == OP_EVOLVE && from_run_reg && run) begin
                        state_next = PACE;
                        pace_entry = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            PACE: begin
                // Loads preempt pacing; step is deliberately ignored here.
                if (load) begin
                    op_next       = OP_LOAD_SEED;
                    from_run_next = 1'b0;
                    state_next    = ISSUE;
                end else if (rundom) begin
                    op_next       = OP_LOAD_RAND;
                    from_run_next = 1'b0;
                    state_next    = ISSUE;
                end else if (!run || stable_reg) begin
                    state_next = IDLE;
                end else if (tick_term) begin
                    op_next       = OP_EVOLVE;
                    from_run_next = 1'b1;
                    state_next    = ISSUE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gen_reg       <= '0;
            stable_reg    <= 1'b0;
            prev_grid_reg <= '0;
        end else if (ack_done) begin
            prev_grid_reg <= grid;
            if (op_reg == OP_EVOLVE) begin
                if (gen_reg != '1) begin
                    gen_reg <= gen_reg + 1'b1;
                end
                stable_reg <= (grid == prev_grid_reg);
            end else begin
                gen_reg    <= '0;
                stable_reg <= 1'b0;
            end
        end
    end

    assign grid_req  = (state_reg == ISSUE) || (state_reg == WAIT);
    assign grid_op   = op_reg;
    assign gen_count = gen_reg;
    assign stable    = stable_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_life_gen_sequencer.sv
// Scoreboard bench for life_gen_sequencer with a datapath model that acks 2 cycles after req.
module tb_life_gen_sequencer;

    import life_pkg::*;

    localparam int TICK_DIV = 4;
    localparam int GEN_W    = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              load = 1'b0;
    logic              rundom = 1'b0;
    logic              step = 1'b0;
    logic              run = 1'b0;
    logic [63:0]       grid_val = '0;
    logic              dp_ack = 1'b0;
    logic              stray_ack = 1'b0;
    logic              grid_ack;
    logic              grid_req;
    logic [1:0]        grid_op;
    logic [GEN_W-1:0]  gen_count;
    logic              stable;
    logic              busy;

    assign grid_ack = dp_ack | stray_ack;

    life_gen_sequencer #(
        .TICK_DIV(TICK_DIV),
        .GEN_W   (GEN_W),
        .GRID_W  (64)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .rundom   (rundom),
        .step     (step),
        .run      (run),
        .grid     (grid_val),
        .grid_ack (grid_ack),
        .grid_req (grid_req),
        .grid_op  (grid_op),
        .gen_count(gen_count),
        .stable   (stable),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        int         gen;
        logic       stab;
        int         gap;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          ack_seen = 0;
    logic [63:0] seed_val = 64'h4206_9960_2400_0700;
    logic [63:0] rand_val = '0;
    logic [63:0] board = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h (t=%0t)", name, act, $time);
        end
    endtask

    task automatic push(input logic [1:0] op, input int gen, input logic stab, input int gap);
        exp_t e;
        e.op = op; e.gen = gen; e.stab = stab; e.gap = gap;
        sbq.push_back(e);
    endtask

    // Datapath model: ack on the third cycle of req, returning the board for the op.
    // EVOLVE rotates the board by 9 bits, so only all-zero/all-one boards are fixed points.
    int age = 0;
    always @(posedge clk) begin
        #1;
        if (reset || !grid_req) begin
            age    = 0;
            dp_ack = 1'b0;
        end else begin
            age++;
            if (age == 3) begin
                case (grid_op)
                    OP_LOAD_SEED: board = seed_val;
                    OP_LOAD_RAND: board = rand_val;
                    OP_EVOLVE:    board = {board[54:0], board[63:55]};
                    default:      board = board;
                endcase
                grid_val = board;
                dp_ack   = 1'b1;
            end else begin
                dp_ack = 1'b0;
            end
        end
    end

    // Monitor: pops one expectation per req, checks op and pacing, then post-ack state.
    logic req_prev = 1'b0;
    logic in_flight = 1'b0;
    logic post_pending = 1'b0;
    int   last_ack_cycle = 0;
    exp_t cur;
    always @(negedge clk) begin
        if (reset) begin
            in_flight    = 1'b0;
            post_pending = 1'b0;
        end
        if (post_pending) begin
            chk("post_gen_count", 64'(gen_count), 64'(cur.gen));
            chk("post_stable", 64'(stable), 64'(cur.stab));
            chk("post_req_drop", 64'(grid_req), 64'd0);
            chk("post_op_nop", 64'(grid_op), 64'(OP_NOP));
            post_pending = 1'b0;
        end
        if (grid_req && !req_prev) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_req: got op %0d expected no request (t=%0t)", grid_op, $time);
            end else begin
                cur = sbq.pop_front();
                chk("req_op", 64'(grid_op), 64'(cur.op));
                if (cur.gap >= 0) chk("pace_gap", 64'(cyc - last_ack_cycle), 64'(cur.gap));
                in_flight = 1'b1;
            end
        end
        if (grid_ack && grid_req && in_flight) begin
            ack_seen++;
            last_ack_cycle = cyc;
            post_pending   = 1'b1;
            in_flight      = 1'b0;
        end
        req_prev = grid_req;
    end

    task automatic pulse(input logic l, input logic r, input logic s);
        @(posedge clk); #1;
        load = l; rundom = r; step = s;
        @(posedge clk); #1;
        load = 1'b0; rundom = 1'b0; step = 1'b0;
        @(negedge clk);
        chk("req_latency", 64'(grid_req), 64'd1);
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout: got busy=1 expected busy=0 within 100 cycles");
        end
    endtask

    initial begin
        int guard;
        int target;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req", 64'(grid_req), 64'd0);
        chk("reset_op", 64'(grid_op), 64'(OP_NOP));
        chk("reset_gen", 64'(gen_count), 64'd0);
        chk("reset_stable", 64'(stable), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Seed load
        push(OP_LOAD_SEED, 0, 1'b0, -1);
        pulse(1'b1, 1'b0, 1'b0);
        wait_idle();

        // load and rundom together: a single LOAD_SEED
        push(OP_LOAD_SEED, 0, 1'b0, -1);
        pulse(1'b1, 1'b1, 1'b0);
        wait_idle();
        repeat (8) @(negedge clk);
        chk("no_extra_txn", 64'(sbq.size()), 64'd0);

        // Three single steps
        for (int i = 1; i <= 3; i++) begin
            push(OP_EVOLVE, i, 1'b0, -1);
            pulse(1'b0, 1'b0, 1'b1);
            wait_idle();
        end

        // Run mode: six paced generations, then drop run while pacing
        for (int i = 4; i <= 9; i++) push(OP_EVOLVE, i, 1'b0, (i == 4) ? -1 : TICK_DIV);
        target = ack_seen + 6;
        @(posedge clk); #1;
        run = 1'b1;
        guard = 0;
        while (ack_seen < target && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (ack_seen < target) begin
            checks++;
            failures++;
            $display("FAIL run_acks: got %0d acks expected %0d", ack_seen, target);
        end
        @(posedge clk); #1;
        run = 1'b0;
        repeat (10) @(negedge clk);
        chk("run_drop_idle", 64'(busy), 64'd0);
        chk("run_drop_queue", 64'(sbq.size()), 64'd0);

        // Saturation at 15 for a 4-bit counter
        for (int i = 10; i <= 16; i++) begin
            push(OP_EVOLVE, (i > 15) ? 15 : i, 1'b0, -1);
            pulse(1'b0, 1'b0, 1'b1);
            wait_idle();
        end

        // Stray ack outside WAIT is ignored
        @(posedge clk); #1;
        stray_ack = 1'b1;
        @(posedge clk); #1;
        stray_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack_gen", 64'(gen_count), 64'd15);
        chk("stray_ack_busy", 64'(busy), 64'd0);

        // All-zero board under run: one EVOLVE, then stable halts running
        rand_val = '0;
        push(OP_LOAD_RAND, 0, 1'b0, -1);
        pulse(1'b0, 1'b1, 1'b0);
        wait_idle();
        push(OP_EVOLVE, 1, 1'b1, -1);
        @(posedge clk); #1;
        run = 1'b1;
        repeat (15) @(negedge clk);
        chk("stable_halt_busy", 64'(busy), 64'd0);
        chk("stable_halt_queue", 64'(sbq.size()), 64'd0);

        // Step while stable still evolves
        push(OP_EVOLVE, 2, 1'b1, -1);
        pulse(1'b0, 1'b0, 1'b1);
        wait_idle();
        @(posedge clk); #1;
        run = 1'b0;

        // Random load clears stable
        rand_val = 64'h0123_4567_89ab_cdef;
        push(OP_LOAD_RAND, 0, 1'b0, -1);
        pulse(1'b0, 1'b1, 1'b0);
        wait_idle();
        push(OP_EVOLVE, 1, 1'b0, -1);
        pulse(1'b0, 1'b0, 1'b1);
        wait_idle();

        // Reset while waiting for ack
        push(OP_EVOLVE, 2, 1'b0, -1);
        pulse(1'b0, 1'b0, 1'b1);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("midwait_reset_req", 64'(grid_req), 64'd0);
        chk("midwait_reset_busy", 64'(busy), 64'd0);
        chk("midwait_reset_gen", 64'(gen_count), 64'd0);
        chk("midwait_reset_op", 64'(grid_op), 64'(OP_NOP));
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("final_queue", 64'(sbq.size()), 64'd0);
        chk("final_busy", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
